// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_scheduler
// Description : Obstacle lane sequencer for a side-scrolling game. Each
//               accepted game tick advances an external random-bit
//               generator, reads the random bit back, decides whether to
//               spawn an obstacle and shifts the lane one cell.
//               A tick is accepted only in IDLE. Its lane update is visible
//               four cycles after the tick.
// Ports       : clk_i      - clock, rising edge
//               rst_i      - synchronous active-high reset
//               run_i      - game running enable (sampled in IDLE only)
//               tick_i     - one-cycle game-step strobe
//               rand_i     - random bit, valid one cycle after lfsr_en_o
//               lfsr_en_o  - one-cycle advance pulse for the random source
//               lane_o     - occupancy map, bit 0 newest cell
//               front_o    - cell at the player (lane_o[LANE_W-1])
//               spawn_o    - one-cycle pulse after an obstacle is inserted
//               score_o    - saturating count of obstacles that left the lane
//               overrun_o  - sticky flag, a tick arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_scheduler #(
    parameter int LANE_W  = 16,
    parameter int MIN_GAP = 3,
    parameter int MAX_GAP = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              tick_i,
    input  logic              rand_i,
    output logic              lfsr_en_o,
    output logic [LANE_W-1:0] lane_o,
    output logic              front_o,
    output logic              spawn_o,
    output logic [15:0]       score_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [3:0]  C_MIN_GAP   = 4'(MIN_GAP);
    localparam logic [3:0]  C_MAX_GAP   = 4'(MAX_GAP);
    localparam logic [15:0] C_SCORE_MAX = 16'hFFFF;

    state_t              state_q,   state_d;
    logic [LANE_W-1:0]   lane_q,    lane_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic [15:0]         score_q,   score_d;
    logic                rand_q,    rand_d;
    logic                spawn_q,   spawn_d;
    logic                overrun_q, overrun_d;
    logic                lfsr_en_w;
    logic                spawn_w;

    // Spawn decision uses the gap count as it stood before this commit.
    assign spawn_w = ((gap_cnt_q >= C_MIN_GAP) && rand_q) || (gap_cnt_q >= C_MAX_GAP);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        gap_cnt_d = gap_cnt_q;
        score_d   = score_q;
        rand_d    = rand_q;
        spawn_d   = 1'b0;
        overrun_d = overrun_q;
        lfsr_en_w = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick_i && run_i) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                lfsr_en_w = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                rand_d  = rand_i;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                lane_d  = {lane_q[LANE_W-2:0], spawn_w};
                spawn_d = spawn_w;
                if (spawn_w) begin
                    gap_cnt_d = 4'd0;
                end else if (gap_cnt_q < C_MAX_GAP) begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
                // The front cell is about to shift out: one obstacle passed.
                if (lane_q[LANE_W-1] && (score_q != C_SCORE_MAX)) begin
                    score_d = score_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any tick seen while a previous one is still in flight is lost;
        // run_i is irrelevant here because the sequence is already committed.
        if (tick_i && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            lane_q    <= '0;
            gap_cnt_q <= 4'd0;
            score_q   <= 16'd0;
            rand_q    <= 1'b0;
            spawn_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            gap_cnt_q <= gap_cnt_d;
            score_q   <= score_d;
            rand_q    <= rand_d;
            spawn_q   <= spawn_d;
            overrun_q <= overrun_d;
        end
    end

    // Decoded straight from the REQ state so the advance pulse lines up with
    // the cycle after tick acceptance and can never repeat for one tick.
    assign lfsr_en_o = lfsr_en_w;
    assign lane_o    = lane_q;
    assign front_o   = lane_q[LANE_W-1];
    assign spawn_o   = spawn_q;
    assign score_o   = score_q;
    assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_scheduler
// Description : Self-checking bench for obstacle_scheduler. Stimulus pushes
//               the expected post-commit lane/spawn/score into a queue; a
//               monitor pops and compares three cycles after each advance
//               pulse from the DUT. Directed checks cover reset, overrun,
//               run gating and reset during an in-flight tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_scheduler;

    typedef struct {
        logic [15:0] lane;
        logic        spawn;
        logic [15:0] score;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        run_i = 1'b0;
    logic        tick_i = 1'b0;
    logic        rand_i = 1'b0;
    logic        lfsr_en_o;
    logic [15:0] lane_o;
    logic        front_o;
    logic        spawn_o;
    logic [15:0] score_o;
    logic        overrun_o;

    int checks   = 0;
    int failures = 0;
    int lfsr_cnt = 0;
    int pend     = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [15:0] m_lane;
    logic [15:0] m_score;
    int          m_gap;

    obstacle_scheduler #(.LANE_W(16), .MIN_GAP(3), .MAX_GAP(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .run_i    (run_i),
        .tick_i   (tick_i),
        .rand_i   (rand_i),
        .lfsr_en_o(lfsr_en_o),
        .lane_o   (lane_o),
        .front_o  (front_o),
        .spawn_o  (spawn_o),
        .score_o  (score_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the lane update for an advance pulse seen at negedge k is
    // visible at negedge k+3.
    always @(negedge clk) begin
        if (rst_i) begin
            pend = 0;
        end else begin
            if (pend != 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected: lane 0x%0h with no expectation", lane_o);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_lane",  {16'd0, lane_o},  {16'd0, e.lane});
                        check("sb_spawn", {31'd0, spawn_o}, {31'd0, e.spawn});
                        check("sb_score", {16'd0, score_o}, {16'd0, e.score});
                    end
                end
            end
            if (lfsr_en_o) begin
                lfsr_cnt++;
                pend = 3;
            end
        end
    end

    task automatic model_reset();
        m_lane  = 16'd0;
        m_score = 16'd0;
        m_gap   = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_i = 1'b0;
        model_reset();
    endtask

    // One tick, spaced 8 cycles. Expectation pushed before the DUT can respond.
    task automatic do_tick();
        logic sp;
        exp_t e;
        if (run_i) begin
            sp = ((m_gap >= 3) && rand_i) || (m_gap >= 8);
            if (m_lane[15] && m_score != 16'hFFFF) m_score = m_score + 16'd1;
            m_lane = {m_lane[14:0], sp};
            if (sp) m_gap = 0;
            else if (m_gap < 8) m_gap = m_gap + 1;
            e.lane = m_lane; e.spawn = sp; e.score = m_score;
            exp_q.push_back(e);
        end
        @(posedge clk); #2 tick_i = 1'b1;
        @(posedge clk); #2 tick_i = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    initial begin
        int lc;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        @(negedge clk);
        check("rst_lane",    {16'd0, lane_o},  32'h0);
        check("rst_score",   {16'd0, score_o}, 32'h0);
        check("rst_overrun", {31'd0, overrun_o}, 32'h0);
        check("rst_spawn",   {31'd0, spawn_o},   32'h0);
        check("rst_lfsr",    {31'd0, lfsr_en_o}, 32'h0);

        // Random bit high: spawns on every fourth tick.
        run_i = 1'b1; rand_i = 1'b1;
        repeat (3) do_tick();
        check("r1_no_spawn_3", {16'd0, lane_o}, 32'h0);
        do_tick();
        check("r1_lane_t4", {16'd0, lane_o}, 32'h0001);
        repeat (4) do_tick();
        check("r1_lane_t8", {16'd0, lane_o}, 32'h0011);

        // Reset while in WAIT with lane 0x0011.
        @(posedge clk); #2 tick_i = 1'b1;
        @(posedge clk); #2 tick_i = 1'b0;
        @(posedge clk); #2 rst_i = 1'b1;
        check("rw_in_wait", {30'd0, dut.state_q}, 32'd2);
        @(posedge clk); #2 rst_i = 1'b0;
        model_reset();
        @(negedge clk);
        check("rw_state", {30'd0, dut.state_q}, 32'd0);
        check("rw_lane",  {16'd0, lane_o},  32'h0);
        check("rw_score", {16'd0, score_o}, 32'h0);
        check("rw_spawn", {31'd0, spawn_o}, 32'h0);
        repeat (4) @(posedge clk);

        // Random bit low: forced spawn on tick 9.
        do_reset();
        rand_i = 1'b0;
        repeat (8) do_tick();
        check("r0_no_spawn_8", {16'd0, lane_o}, 32'h0);
        do_tick();
        check("r0_lane_t9", {16'd0, lane_o}, 32'h0001);
        check("r0_gap_t9",  {28'd0, dut.gap_cnt_q}, 32'h0);

        // Twenty ticks: first obstacle reaches the front, then exits.
        do_reset();
        rand_i = 1'b1;
        repeat (19) do_tick();
        check("sc_front_t19", {31'd0, front_o}, 32'h1);
        check("sc_score_t19", {16'd0, score_o}, 32'h0);
        do_tick();
        check("sc_score_t20", {16'd0, score_o}, 32'h1);

        // Run low: ticks ignored entirely.
        run_i = 1'b0;
        lc = lfsr_cnt;
        repeat (5) do_tick();
        check("nr_lfsr",  lfsr_cnt,          lc);
        check("nr_lane",  {16'd0, lane_o},   {16'd0, m_lane});
        check("nr_score", {16'd0, score_o},  {16'd0, m_score});

        // Back-to-back ticks: one advance pulse, sticky overrun.
        do_reset();
        run_i = 1'b1;
        begin
            exp_t e;
            e.lane = 16'd0; e.spawn = 1'b0; e.score = 16'd0;
            exp_q.push_back(e);
        end
        lc = lfsr_cnt;
        @(posedge clk); #2 tick_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ov_lfsr_n1",    {31'd0, lfsr_en_o}, 32'h1);
        check("ov_flag_n1",    {31'd0, overrun_o}, 32'h0);
        @(posedge clk); #2 tick_i = 1'b0;
        @(negedge clk);
        check("ov_flag_n2",    {31'd0, overrun_o}, 32'h1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ov_flag_hold",  {31'd0, overrun_o}, 32'h1);
        check("ov_lfsr_count", lfsr_cnt, lc + 1);
        do_reset();
        @(negedge clk);
        check("ov_flag_clear", {31'd0, overrun_o}, 32'h0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
